// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: instruction fetch and load/store share one memory port.
// Load/store normally wins, but a waiting fetch is let through after MAX_LS_STREAK load/store grants.
module mem_port_arbiter #(
    parameter int MAX_LS_STREAK = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_wstrb,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int STREAK_W = (MAX_LS_STREAK < 1) ? 1 : $clog2(MAX_LS_STREAK + 1);
    localparam int WAIT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);
    localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM,
        S_RESP
    } state_t;

    state_t               r_state;
    logic                 r_grantLs;
    logic [STREAK_W-1:0]  r_lsStreak;
    logic [WAIT_W-1:0]    r_waitCnt;
    logic                 r_memValid;
    logic                 r_memWe;
    logic [31:0]          r_memAddr;
    logic [31:0]          r_memWdata;
    logic [3:0]           r_memWstrb;
    logic                 r_ifAck;
    logic [31:0]          r_ifRdata;
    logic                 r_ifErr;
    logic                 r_lsAck;
    logic [31:0]          r_lsRdata;
    logic                 r_lsErr;

    logic                 w_grantLs;
    logic                 w_grantIf;
    logic                 w_timeout;
    logic                 w_done;
    logic [STREAK_W-1:0]  w_streakInc;

    // Load/store has priority unless the fetch side has already been starved for a full streak.
    assign w_grantLs   = ls_req && !(if_req && (r_lsStreak == STREAK_MAX));
    assign w_grantIf   = if_req && !w_grantLs;
    assign w_timeout   = !mem_ready && (r_waitCnt == WAIT_LAST);
    assign w_done      = mem_ready || w_timeout;
    assign w_streakInc = (r_lsStreak == STREAK_MAX) ? r_lsStreak : r_lsStreak + STREAK_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grantLs  <= 1'b0;
            r_lsStreak <= '0;
            r_waitCnt  <= '0;
            r_memValid <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_memWstrb <= '0;
            r_ifAck    <= 1'b0;
            r_ifRdata  <= '0;
            r_ifErr    <= 1'b0;
            r_lsAck    <= 1'b0;
            r_lsRdata  <= '0;
            r_lsErr    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grantLs) begin
                        r_grantLs  <= 1'b1;
                        r_memValid <= 1'b1;
                        r_memWe    <= ls_we;
                        r_memAddr  <= ls_addr;
                        r_memWdata <= ls_wdata;
                        r_memWstrb <= ls_wstrb;
                        r_waitCnt  <= '0;
                        r_lsStreak <= if_req ? w_streakInc : '0;
                        r_state    <= S_MEM;
                    end else if (w_grantIf) begin
                        r_grantLs  <= 1'b0;
                        r_memValid <= 1'b1;
                        r_memWe    <= 1'b0;
                        r_memAddr  <= if_addr;
                        r_memWdata <= '0;
                        r_memWstrb <= '0;
                        r_waitCnt  <= '0;
                        r_lsStreak <= '0;
                        r_state    <= S_MEM;
                    end
                end
                S_MEM: begin
                    // A completing memory beats the timeout when both land on the last wait cycle.
                    if (w_done) begin
                        r_memValid <= 1'b0;
                        r_state    <= S_RESP;
                        if (r_grantLs) begin
                            r_lsAck   <= 1'b1;
                            r_lsRdata <= mem_ready ? mem_rdata : 32'h0;
                            r_lsErr   <= !mem_ready;
                        end else begin
                            r_ifAck   <= 1'b1;
                            r_ifRdata <= mem_ready ? mem_rdata : 32'h0;
                            r_ifErr   <= !mem_ready;
                        end
                    end else begin
                        r_waitCnt <= r_waitCnt + WAIT_W'(1);
                    end
                end
                S_RESP: begin
                    r_ifAck <= 1'b0;
                    r_lsAck <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_valid = r_memValid;
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign mem_wstrb = r_memWstrb;
    assign if_ack    = r_ifAck;
    assign if_rdata  = r_ifRdata;
    assign if_err    = r_ifErr;
    assign ls_ack    = r_lsAck;
    assign ls_rdata  = r_lsRdata;
    assign ls_err    = r_lsErr;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: requester tasks queue expected responses,
// a behavioural memory answers the port, and a monitor checks every ack against the queues.
module tb_mem_port_arbiter;

    localparam int MAX_LS = 4;
    localparam int TMO    = 8;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wstrb;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;

    mem_port_arbiter #(.MAX_LS_STREAK(MAX_LS), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t       ifExpQ[$];
    resp_t       lsExpQ[$];
    int          ackLog[$];
    logic [31:0] goldMem[int unsigned];
    logic [31:0] slvMem[int unsigned];

    int          checks = 0;
    int          errors = 0;
    int          ifDelay = 0, lsDelay = 0;
    logic        ifPending = 1'b0, lsPending = 1'b0;
    logic [31:0] ifAddrCur, lsAddrCur, lsWdataCur;
    logic        lsWeCur;
    logic [3:0]  lsWstrbCur;
    int          lastTxnLen = 0;
    int          lat, latA, latB;

    logic        slvInTxn = 1'b0, slvIsLs = 1'b0;
    int          slvCyc = 0, slvDelay = 0, slvIdle = 100;

    logic        prevRst = 1'b1, prevIfAck = 1'b0, prevLsAck = 1'b0;
    logic [31:0] lastIfR = '0, lastLsR = '0;
    logic        lastIfE = 1'b0, lastLsE = 1'b0;
    resp_t       monE;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] fetchWord(input logic [31:0] a);
        if (a == 32'h1C) return 32'h0040_0CEF;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] memInit(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5A5, ~a[15:0]};
    endfunction

    function automatic logic [31:0] wrResp(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] goldRead(input logic [31:0] a);
        if (goldMem.exists(32'(a[31:2]))) return goldMem[32'(a[31:2])];
        return memInit(a);
    endfunction

    function automatic logic [31:0] slvRead(input logic [31:0] a);
        if (slvMem.exists(32'(a[31:2]))) return slvMem[32'(a[31:2])];
        return memInit(a);
    endfunction

    function automatic int pickDelay();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return TMO - 1;
        if (r == 1) return TMO;
        if (r == 2) return TMO + 12;
        return $urandom_range(0, 3);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Fetch requester: queues the expected response, holds the request until the cycle after ack.
    task automatic doIf(input logic [31:0] addr, input int delay, output int latency);
        resp_t e;
        e.err   = (delay >= TMO);
        e.rdata = e.err ? 32'h0 : fetchWord(addr);
        ifExpQ.push_back(e);
        ifAddrCur = addr;
        ifDelay   = delay;
        ifPending = 1'b1;
        if_addr   = addr;
        if_req    = 1'b1;
        latency   = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (if_ack === 1'b1) begin
                latency = k;
                break;
            end
        end
        if (latency < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL if_ack_wait actual=no ack required=ack within 200 cycles");
            if (ifExpQ.size() > 0) void'(ifExpQ.pop_back());
        end
        @(posedge clk);
        #1;
        if_req    = 1'b0;
        ifPending = 1'b0;
        if_addr   = $urandom;
    endtask

    task automatic doLs(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int delay, output int latency);
        resp_t e;
        e.err   = (delay >= TMO);
        e.rdata = e.err ? 32'h0 : (we ? wrResp(addr) : goldRead(addr));
        if (we && !e.err) goldMem[32'(addr[31:2])] = mergeBytes(goldRead(addr), wdata, strb);
        lsExpQ.push_back(e);
        lsWeCur    = we;
        lsAddrCur  = addr;
        lsWdataCur = wdata;
        lsWstrbCur = strb;
        lsDelay    = delay;
        lsPending  = 1'b1;
        ls_we      = we;
        ls_addr    = addr;
        ls_wdata   = wdata;
        ls_wstrb   = strb;
        ls_req     = 1'b1;
        latency    = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ls_ack === 1'b1) begin
                latency = k;
                break;
            end
        end
        if (latency < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL ls_ack_wait actual=no ack required=ack within 200 cycles");
            if (lsExpQ.size() > 0) void'(lsExpQ.pop_back());
        end
        @(posedge clk);
        #1;
        ls_req    = 1'b0;
        lsPending = 1'b0;
        ls_we     = 1'($urandom);
        ls_addr   = $urandom;
        ls_wdata  = $urandom;
        ls_wstrb  = 4'($urandom);
    endtask

    task automatic applyReset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic applyStimulus();
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int gap;
                    gap = $urandom_range(0, 3);
                    if (gap > 0) begin
                        repeat (gap) @(posedge clk);
                        #1;
                    end
                    doIf({20'h0, 10'($urandom_range(0, 1023)), 2'b00}, pickDelay(), latA);
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    int gap;
                    gap = $urandom_range(0, 2);
                    if (gap > 0) begin
                        repeat (gap) @(posedge clk);
                        #1;
                    end
                    doLs(1'($urandom), {28'h1000_000, 2'b00, 2'b00} | {26'h0, 4'($urandom), 2'b00},
                         $urandom, 4'($urandom), pickDelay(), latB);
                end
            end
        join
    endtask

    // Behavioural memory: answers after the delay the owning requester asked for, random noise otherwise.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_valid === 1'b1) begin
                if (!slvInTxn) begin
                    slvInTxn = 1'b1;
                    slvCyc   = 0;
                    if (lsPending && ifPending) slvIsLs = mem_addr[28];
                    else slvIsLs = lsPending;
                    slvDelay = slvIsLs ? lsDelay : ifDelay;
                    checkOutput("idle_gap", 32'(slvIdle >= 2), 32'd1);
                    checkOutput("busy_in_mem", 32'(busy), 32'd1);
                    if (slvIsLs) begin
                        checkOutput("ls_mem_addr", mem_addr, lsAddrCur);
                        checkOutput("ls_mem_we", 32'(mem_we), 32'(lsWeCur));
                        checkOutput("ls_mem_wdata", mem_wdata, lsWdataCur);
                        checkOutput("ls_mem_wstrb", 32'(mem_wstrb), 32'(lsWstrbCur));
                    end else begin
                        checkOutput("if_mem_addr", mem_addr, ifAddrCur);
                        checkOutput("if_mem_we", 32'(mem_we), 32'd0);
                        checkOutput("if_mem_wstrb", 32'(mem_wstrb), 32'd0);
                    end
                end else begin
                    slvCyc++;
                end
                if (slvCyc == slvDelay) begin
                    mem_ready = 1'b1;
                    if (mem_we) begin
                        mem_rdata = wrResp(mem_addr);
                        slvMem[32'(mem_addr[31:2])] = mergeBytes(slvRead(mem_addr), mem_wdata, mem_wstrb);
                    end else begin
                        mem_rdata = slvIsLs ? slvRead(mem_addr) : fetchWord(mem_addr);
                    end
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                end
                slvIdle = 0;
            end else begin
                if (slvInTxn) begin
                    slvInTxn   = 1'b0;
                    lastTxnLen = slvCyc + 1;
                end
                slvIdle++;
                mem_ready = 1'($urandom);
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: pops the scoreboard on each ack and checks that response data holds between acks.
    initial begin
        forever begin
            @(negedge clk);
            if (prevRst) begin
                lastIfR = '0;
                lastIfE = 1'b0;
                lastLsR = '0;
                lastLsE = 1'b0;
            end else begin
                if (if_ack === 1'b1) begin
                    ackLog.push_back(1);
                    checkOutput("ack_exclusive", 32'(ls_ack), 32'd0);
                    checkOutput("if_ack_pulse", 32'(prevIfAck), 32'd0);
                    if (ifExpQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL if_ack_unexpected actual=ack required=no ack");
                    end else begin
                        monE = ifExpQ.pop_front();
                        checkOutput("if_rdata", if_rdata, monE.rdata);
                        checkOutput("if_err", 32'(if_err), 32'(monE.err));
                        lastIfR = monE.rdata;
                        lastIfE = monE.err;
                    end
                end else begin
                    checkOutput("if_rdata_hold", if_rdata, lastIfR);
                    checkOutput("if_err_hold", 32'(if_err), 32'(lastIfE));
                end
                if (ls_ack === 1'b1) begin
                    ackLog.push_back(0);
                    checkOutput("ls_ack_pulse", 32'(prevLsAck), 32'd0);
                    if (lsExpQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL ls_ack_unexpected actual=ack required=no ack");
                    end else begin
                        monE = lsExpQ.pop_front();
                        checkOutput("ls_rdata", ls_rdata, monE.rdata);
                        checkOutput("ls_err", 32'(ls_err), 32'(monE.err));
                        lastLsR = monE.rdata;
                        lastLsE = monE.err;
                    end
                end else begin
                    checkOutput("ls_rdata_hold", ls_rdata, lastLsR);
                    checkOutput("ls_err_hold", 32'(ls_err), 32'(lastLsE));
                end
            end
            prevRst   = (reset !== 1'b0);
            prevIfAck = (if_ack === 1'b1);
            prevLsAck = (ls_ack === 1'b1);
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios first, then the randomized mix.
    initial begin
        reset    = 1'b1;
        if_req   = 1'b1;
        if_addr  = 32'h1C;
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 32'h100;
        ls_wdata = 32'hFFFF_FFFF;
        ls_wstrb = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mem_valid", 32'(mem_valid), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_if_ack", 32'(if_ack), 32'd0);
        checkOutput("rst_ls_ack", 32'(ls_ack), 32'd0);
        checkOutput("rst_if_err", 32'(if_err), 32'd0);
        checkOutput("rst_ls_err", 32'(ls_err), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        checkOutput("rst_if_rdata", if_rdata, 32'd0);
        checkOutput("rst_ls_rdata", ls_rdata, 32'd0);
        if_req = 1'b0;
        ls_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        doIf(32'h1C, 0, lat);
        checkOutput("fetch_latency", 32'(lat), 32'd2);

        doLs(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 3, lat);
        checkOutput("store_latency", 32'(lat), 32'd5);
        checkOutput("store_valid_len", 32'(lastTxnLen), 32'd4);
        doLs(1'b0, 32'h100, 32'h0, 4'h0, 0, lat);

        doIf(32'h40, TMO + 20, lat);
        checkOutput("timeout_valid_len", 32'(lastTxnLen), 32'(TMO));
        checkOutput("timeout_latency", 32'(lat), 32'(TMO + 1));
        doIf(32'h44, 2, lat);
        checkOutput("post_timeout_len", 32'(lastTxnLen), 32'd3);
        doLs(1'b0, 32'h1000_0008, 32'h0, 4'h3, TMO - 1, lat);
        checkOutput("last_cycle_ready_len", 32'(lastTxnLen), 32'(TMO));

        fork
            doLs(1'b0, 32'h1000_0010, 32'h0, 4'h0, 5, lat);
            begin
                for (int k = 0; k < 50; k++) begin
                    @(negedge clk);
                    if (mem_valid === 1'b1) break;
                end
                @(posedge clk);
                #1;
                reset   = 1'b1;
                lsDelay = 1;
                @(negedge clk);
                checkOutput("midmem_valid_before", 32'(mem_valid), 32'd1);
                @(negedge clk);
                checkOutput("midmem_valid_after", 32'(mem_valid), 32'd0);
                checkOutput("midmem_ls_ack", 32'(ls_ack), 32'd0);
                checkOutput("midmem_busy", 32'(busy), 32'd0);
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
        join

        applyReset(2);
        ackLog.delete();
        fork
            begin
                for (int i = 0; i < 6; i++) doIf({20'h0, 10'($urandom_range(0, 1023)), 2'b00}, 0, latA);
            end
            begin
                for (int i = 0; i < 30; i++)
                    doLs(1'($urandom), {28'h1000_000, 4'($urandom_range(0, 15))} & 32'hFFFF_FFFC,
                         $urandom, 4'($urandom), $urandom_range(0, 2), latB);
            end
        join
        if (ackLog.size() < 30) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant_order_count actual=%0d required=30 or more", ackLog.size());
        end else begin
            for (int i = 0; i < 30; i++)
                checkOutput($sformatf("grant_order_%0d", i), 32'(ackLog[i]),
                            ((i % (MAX_LS + 1)) == MAX_LS) ? 32'd1 : 32'd0);
        end

        applyStimulus();
        repeat (3) @(posedge clk);
        checkOutput("if_queue_drained", 32'(ifExpQ.size()), 32'd0);
        checkOutput("ls_queue_drained", 32'(lsExpQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
